// File: rtl/mdu_hilo_if.sv
// Bus interface for mdu_hilo: operation launch, MTHI/MTLO writes and HI/LO results.
interface mdu_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: launches ops and writes HI/LO, reads status and results.
  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Iterative shift-add multiply and restoring divide on operand magnitudes,
// signs applied in a final fix-up cycle.
// Optional feature macro: MDU_EARLY_TERM_EN (multiply stops once the
// remaining multiplier bits are all zero; results are unchanged).
module mdu_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  mdu_hilo_if.slave bus
);
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [W2-1:0]    acc;      // product accumulator, or {remainder, quotient} for divide
  logic [WIDTH-1:0] divisor;
  logic             neg_q;    // product / quotient must be negated
  logic             neg_r;    // remainder must be negated
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             is_signed;
  logic             is_div;
  logic             by_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   div_tmp;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [W2-1:0]    acc_div_next;
  logic [W2-1:0]    acc_mul_next;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             mult_last;
  logic             div_last;
  logic             mult_skip;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // Operand magnitudes, one iteration step of each datapath, and signed fix-up values.
  always_comb begin
    is_signed    = ~op_q[0];
    is_div       = op_q[1];
    by_zero      = is_div && (b_q == '0);
    mag_a        = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b        = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    // Shifted partial remainder needs one extra bit before the compare.
    div_tmp      = acc[W2-1:WIDTH-1];
    div_diff     = div_tmp - {1'b0, divisor};
    div_ge       = ~div_diff[WIDTH];
    acc_div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                    acc[WIDTH-2:0], div_ge};
    acc_mul_next = mplier[0] ? (acc + mcand) : acc;
    prod         = neg_q ? -acc : acc;
    quot_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix      = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    div_last     = (cnt == CW'(WIDTH - 1));
`ifdef MDU_EARLY_TERM_EN
    mult_last    = (mplier[WIDTH-1:1] == '0);
    mult_skip    = (mag_b == '0);
`else
    mult_last    = (cnt == CW'(WIDTH - 1));
    mult_skip    = 1'b0;
`endif
  end

  // Control FSM with the datapath and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            b_q    <= bus.b;
            busy_q <= 1'b1;
            state  <= PREP;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        PREP: begin
          cnt   <= '0;
          neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r <= is_signed & a_q[WIDTH-1];
          if (is_div) begin
            acc     <= {{WIDTH{1'b0}}, mag_a};
            divisor <= mag_b;
            state   <= by_zero ? FIX : RUN;
          end else begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            state  <= mult_skip ? FIX : RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            acc <= acc_div_next;
            if (div_last) state <= FIX;
          end else begin
            acc    <= acc_mul_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (mult_last) state <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
          if (by_zero) begin
            lo_q <= '1;
            hi_q <= a_q;
            dz_q <= 1'b1;
          end else if (is_div) begin
            lo_q <= quot_fix;
            hi_q <= rem_fix;
            dz_q <= 1'b0;
          end else begin
            hi_q <= prod[W2-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
            dz_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: vector table plus random ops through a
// result scoreboard, and hand sequences for busy/write/reset corner cases.
module tb_mdu_hilo;
  localparam int unsigned W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[13];

  mdu_hilo_if #(.WIDTH(W)) bus ();
  mdu_hilo #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference results straight from the instruction semantics.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    logic [63:0] p;
    int sx, sy;
    z = 1'b0;
    h = '0;
    l = '0;
    if (o == 2'b00) begin
      p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      h = p[63:32]; l = p[31:0];
    end else if (o == 2'b01) begin
      p = {32'b0, x} * {32'b0, y};
      h = p[63:32]; l = p[31:0];
    end else if (y == '0) begin
      l = '1; h = x; z = 1'b1;
    end else if (o == 2'b11) begin
      l = x / y; h = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      l = x; h = '0;
    end else begin
      sx = x; sy = y;
      l = 32'(sx / sy); h = 32'(sx % sy);
    end
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
`ifdef MDU_EARLY_TERM_EN
    logic [W-1:0] m;
    int idx;
`endif
    if (o[1]) return (y == '0) ? 2 : W + 2;
`ifdef MDU_EARLY_TERM_EN
    m = (o == 2'b00 && y[W-1]) ? -y : y;
    if (m == '0) return 2;
    idx = 0;
    for (int i = 0; i < W; i++) if (m[i]) idx = i;
    return idx + 3;
`else
    return W + 2;
`endif
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic hw, input logic lw, input logic [W-1:0] wd);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    bus.hi_we = hw; bus.lo_we = lw; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.op = ~o; bus.a = ~x; bus.b = $urandom;
  endtask

  task automatic wait_done(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int lat;
    logic ok;
    e.hi = v.hi; e.lo = v.lo; e.dz = v.dz; e.lat = exp_lat(v.op, v.b);
    sb.push_back(e);
    start_op(v.op, v.a, v.b, 1'b0, 1'b0, '0);
    chk("busy_after_start", W'(bus.busy), W'(1));
    wait_done(lat, ok);
    chk("done_seen", W'(ok), W'(1));
    e = sb.pop_front();
    if (ok) begin
      chk("hi", bus.hi, e.hi);
      chk("lo", bus.lo, e.lo);
      chk("div_zero", W'(bus.div_zero), W'(e.dz));
      chk("latency", W'(lat), W'(e.lat));
      chk("busy_at_done", W'(bus.busy), W'(0));
    end
  endtask

  initial begin
    vec_t v;
    int lat;
    int ndone;
    logic ok;

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    tbl[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[2]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    tbl[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[5]  = '{2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1};
    tbl[6]  = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
    tbl[7]  = '{2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0};
    tbl[8]  = '{2'b01, 32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[11] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    tbl[12] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_dz", W'(bus.div_zero), W'(0));
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Random ops checked against the reference model
    for (int i = 0; i < 10; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a  = $urandom;
      v.b  = (i == 4) ? '0 : ($urandom >> $urandom_range(0, 31));
      model(v.op, v.a, v.b, v.hi, v.lo, v.dz);
      run_vec(v);
    end

    // MTHI/MTLO in idle, then start with a simultaneous write: start wins
    @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 32'h22;
    @(posedge clk); #1; bus.hi_we = 1'b0;
    chk("mthi_idle", bus.hi, 32'h22);
    @(negedge clk); bus.lo_we = 1'b1; bus.wdata = 32'h11;
    @(posedge clk); #1; bus.lo_we = 1'b0;
    chk("mtlo_idle", bus.lo, 32'h11);
    start_op(2'b01, 32'd2, 32'd3, 1'b1, 1'b0, 32'h99);
    chk("start_beats_write_hi", bus.hi, 32'h22);
    wait_done(lat, ok);
    chk("start_write_done", W'(ok), W'(1));
    chk("start_write_lo", bus.lo, 32'd6);
    chk("start_write_hi_res", bus.hi, 32'd0);

    // Start/write while busy are dropped; reset mid-operation aborts without done
    @(negedge clk); bus.lo_we = 1'b1; bus.wdata = 32'h11;
    @(posedge clk); #1; bus.lo_we = 1'b0;
    start_op(2'b01, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.lo_we = 1'b1; bus.wdata = 32'hAA;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    chk("busy_write_dropped", bus.lo, 32'h11);
    chk("busy_still_set", W'(bus.busy), W'(1));
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", W'(bus.busy), W'(0));
    chk("abort_hi", bus.hi, '0);
    chk("abort_lo", bus.lo, '0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("abort_no_done", W'(ndone), W'(0));
    chk("abort_idle", W'(bus.busy), W'(0));
    @(negedge clk); bus.lo_we = 1'b1; bus.wdata = 32'h55;
    @(posedge clk); #1; bus.lo_we = 1'b0;
    chk("post_abort_mtlo", bus.lo, 32'h55);
    chk("post_abort_hi", bus.hi, '0);
    chk("scoreboard_empty", W'(sb.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
